// File: rtl/pipelined_rca_addsub_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
//   DEFAULT_WIDTH / DEFAULT_SEG : default operand width and bits per stage
//   stage_ctl_t                 : per-stage record (valid, carry out, signed overflow)
//   cfg_ok()                    : elaboration-time legality check of WIDTH/SEG
package pipelined_rca_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SEG   = 4;

    // Partial sums travel in a separate full-width deskew word per stage,
    // so the record only carries the single-bit state of each stage.
    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } stage_ctl_t;

    function automatic bit cfg_ok(input int width, input int seg);
        return (seg >= 1) && (seg <= width) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/pipelined_rca_addsub_if.sv
// Streaming bus of the pipelined adder/subtractor.
//   in_valid/in_ready   : operand beat handshake (A, B, Cin, Sub)
//   out_valid/out_ready : result beat handshake (Sum, Cout, Overflow)
// master = producer/consumer side, slave = the adder.
interface pipelined_rca_addsub_if
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Overflow;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, Overflow
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, Sum, Cout, Overflow
    );
endinterface

// File: rtl/pipelined_rca_addsub_segment.sv
// SEG-bit combinational ripple adder built from full-adder bit cells.
//   a, b : segment operands        cin  : carry into bit 0
//   sum  : segment sum             cout : carry out of the top bit
//   cmsb : carry into the top bit (for signed overflow detection)
module pipelined_rca_segment
    import pipelined_rca_pkg::*;
#(
    parameter int SEG = DEFAULT_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           cmsb
);
    logic carry;

    // A scalar running carry keeps the chain free of combinational self-loops
    // on a vector.
    always_comb begin
        sum   = '0;
        cmsb  = 1'b0;
        carry = cin;
        for (int i = 0; i < SEG; i++) begin
            if (i == SEG - 1) begin
                cmsb = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

// File: rtl/pipelined_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment per stage,
// carry registered between stages, operands skewed in and partial sums
// deskewed out so one full result is produced per cycle.
//   Clock, Reset : rising-edge clock, synchronous active-high reset
//   bus          : slave side of the operand/result streaming bus
// Latency is STAGES edges counting the accept edge; SEG == WIDTH is a
// single registered adder.
module pipelined_rca_addsub
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG   = DEFAULT_SEG
) (
    input  logic                  Clock,
    input  logic                  Reset,
    pipelined_rca_addsub_if.slave bus
);
    localparam int STAGES = (SEG >= 1) ? (WIDTH / SEG) : 1;

    if (!cfg_ok(WIDTH, SEG)) begin : g_cfg_err
        $error("pipelined_rca_addsub: WIDTH must be a positive multiple of SEG");
    end

    logic             adv;
    logic             accept;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c0_in;

    stage_ctl_t       ctl_w [STAGES];
    logic [WIDTH-1:0] sum_w [STAGES];

    // One global advance: the whole pipe moves only when the output slot is
    // free or being drained.
    assign adv          = !ctl_w[STAGES-1].valid || bus.out_ready;
    assign bus.in_ready = adv && !Reset;
    assign accept       = bus.in_valid && adv && !Reset;

    // Subtract is A + ~B + !Cin. Non-accepted slots are forced to zero so
    // bubbles carry clean data through the pipe.
    assign a_in  = accept ? bus.A : '0;
    assign b_in  = accept ? (bus.Sub ? ~bus.B : bus.B) : '0;
    assign c0_in = accept && (bus.Sub ? !bus.Cin : bus.Cin);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;

        stage_ctl_t       ctl_d, ctl_q;
        logic [WIDTH-1:0] sum_d, sum_q;
        logic [WIDTH-1:0] sum_prev;
        logic [SEG-1:0]   a_seg, b_seg, seg_sum;
        logic             cin_seg, valid_prev, seg_cout, seg_cmsb;

        if (k == 0) begin : g_head
            assign a_seg      = a_in[SEG-1:0];
            assign b_seg      = b_in[SEG-1:0];
            assign cin_seg    = c0_in;
            assign valid_prev = accept;
            assign sum_prev   = '0;
        end else begin : g_body
            // Segment k of the operands is delayed k cycles so it meets the
            // carry of the same beat coming out of stage k-1.
            logic [SEG-1:0] ska_d [k];
            logic [SEG-1:0] ska_q [k];
            logic [SEG-1:0] skb_d [k];
            logic [SEG-1:0] skb_q [k];

            always_comb begin
                for (int d = 0; d < k; d++) begin
                    ska_d[d] = ska_q[d];
                    skb_d[d] = skb_q[d];
                end
                if (adv) begin
                    ska_d[0] = a_in[LO +: SEG];
                    skb_d[0] = b_in[LO +: SEG];
                    for (int d = 1; d < k; d++) begin
                        ska_d[d] = ska_q[d-1];
                        skb_d[d] = skb_q[d-1];
                    end
                end
            end

            always_ff @(posedge Clock) begin
                if (Reset) begin
                    for (int d = 0; d < k; d++) begin
                        ska_q[d] <= '0;
                        skb_q[d] <= '0;
                    end
                end else begin
                    for (int d = 0; d < k; d++) begin
                        ska_q[d] <= ska_d[d];
                        skb_q[d] <= skb_d[d];
                    end
                end
            end

            assign a_seg      = ska_q[k-1];
            assign b_seg      = skb_q[k-1];
            assign cin_seg    = ctl_w[k-1].carry;
            assign valid_prev = ctl_w[k-1].valid;
            assign sum_prev   = sum_w[k-1];
        end

        pipelined_rca_segment #(.SEG(SEG)) u_seg (
            .a    (a_seg),
            .b    (b_seg),
            .cin  (cin_seg),
            .sum  (seg_sum),
            .cout (seg_cout),
            .cmsb (seg_cmsb)
        );

        // The sum word accumulates lower segments as the beat moves down the
        // pipe, which is the output deskew for segment j (STAGES-1-j delays).
        always_comb begin
            ctl_d = ctl_q;
            sum_d = sum_q;
            if (adv) begin
                ctl_d.valid       = valid_prev;
                ctl_d.carry       = seg_cout;
                ctl_d.ovf         = seg_cout ^ seg_cmsb;
                sum_d             = sum_prev;
                sum_d[LO +: SEG]  = seg_sum;
            end
        end

        always_ff @(posedge Clock) begin
            if (Reset) begin
                ctl_q <= '0;
                sum_q <= '0;
            end else begin
                ctl_q <= ctl_d;
                sum_q <= sum_d;
            end
        end

        assign ctl_w[k] = ctl_q;
        assign sum_w[k] = sum_q;
    end

    // Only the last stage's overflow is the full-width signed overflow.
    assign bus.out_valid = ctl_w[STAGES-1].valid;
    assign bus.Sum       = sum_w[STAGES-1];
    assign bus.Cout      = ctl_w[STAGES-1].carry;
    assign bus.Overflow  = ctl_w[STAGES-1].ovf;
endmodule

// File: tb/tb_pipelined_rca_addsub.sv
module tb_pipelined_rca_addsub;
    import pipelined_rca_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_rca_addsub_if #(.WIDTH(W)) bus4 ();
    pipelined_rca_addsub_if #(.WIDTH(W)) bus1 ();
    pipelined_rca_addsub_if #(.WIDTH(W)) bus16 ();

    pipelined_rca_addsub #(.WIDTH(W), .SEG(4)) u_dut4 (
        .Clock (clk), .Reset (rst), .bus (bus4.slave));
    pipelined_rca_addsub #(.WIDTH(W), .SEG(1)) u_dut1 (
        .Clock (clk), .Reset (rst), .bus (bus1.slave));
    pipelined_rca_addsub #(.WIDTH(W), .SEG(16)) u_dut16 (
        .Clock (clk), .Reset (rst), .bus (bus16.slave));

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        res_t        exp;
    } vec_t;

    res_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        logic [15:0] be;
        logic [16:0] full;
        res_t        r;
        be     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, be} + {16'b0, (sub ? ~cin : cin)};
        r.sum  = full[15:0];
        r.cout = full[16];
        r.ovf  = (a[15] == be[15]) && (r.sum[15] != a[15]);
        return r;
    endfunction

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic cin, input logic sub,
                                input logic [15:0] s, input logic co, input logic ov);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.exp.sum = s; v.exp.cout = co; v.exp.ovf = ov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard for the SEG=4 instance: push on accept, pop on drain,
    // and hold-stability checks while the consumer stalls.
    initial begin
        logic held_v;
        res_t held;
        res_t e;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                exp_q.delete();
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    chk("hold_valid", bus4.out_valid, 1);
                    chk("hold_result", {bus4.Sum, bus4.Cout, bus4.Overflow}, held);
                end
                held_v = 1'b0;
                if (bus4.out_valid && !bus4.out_ready) begin
                    chk("stall_in_ready", bus4.in_ready, 0);
                    held_v = 1'b1;
                    held   = {bus4.Sum, bus4.Cout, bus4.Overflow};
                end
                if (bus4.out_valid && bus4.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected actual=%0h required=none",
                                 {bus4.Sum, bus4.Cout, bus4.Overflow});
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_result", {bus4.Sum, bus4.Cout, bus4.Overflow}, e);
                        pops++;
                    end
                end
                if (bus4.in_valid && bus4.in_ready) begin
                    exp_q.push_back(model(bus4.A, bus4.B, bus4.Cin, bus4.Sub));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        vec_t        tbl[7];
        vec_t        sc2[2];
        logic [15:0] ra[20], rb[20];
        logic        rc[20], rs[20];
        int          lat, lat1, lat4, lat16, seen, i, cyc, pops0;
        res_t        r1, r4, r16;

        tbl[0] = mk(16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0);
        tbl[1] = mk(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        tbl[2] = mk(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        tbl[3] = mk(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
        tbl[4] = mk(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
        tbl[5] = mk(16'h0005, 16'h0003, 1, 1, 16'h0001, 1, 0);
        tbl[6] = mk(16'h8000, 16'h8000, 1, 0, 16'h0001, 1, 1);
        sc2[0] = tbl[1];
        sc2[1] = tbl[2];

        rst = 1'b1;
        bus4.in_valid = 0; bus4.out_ready = 1; bus4.A = 0; bus4.B = 0; bus4.Cin = 0; bus4.Sub = 0;
        bus1.in_valid = 0; bus1.out_ready = 1; bus1.A = 0; bus1.B = 0; bus1.Cin = 0; bus1.Sub = 0;
        bus16.in_valid = 0; bus16.out_ready = 1; bus16.A = 0; bus16.B = 0; bus16.Cin = 0; bus16.Sub = 0;

        repeat (2) @(negedge clk);
        #3;
        chk("rst_out_valid", bus4.out_valid, 0);
        chk("rst_result", {bus4.Sum, bus4.Cout, bus4.Overflow}, 0);
        chk("rst_in_ready", bus4.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single beats from the table: latency, result, one-cycle pulse.
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            bus4.in_valid = 1; bus4.A = tbl[t].a; bus4.B = tbl[t].b;
            bus4.Cin = tbl[t].cin; bus4.Sub = tbl[t].sub;
            #1;
            chk($sformatf("tbl%0d_in_ready", t), bus4.in_ready, 1);
            lat = 0;
            for (int c = 1; c <= 20 && lat == 0; c++) begin
                @(negedge clk);
                if (c == 1) bus4.in_valid = 0;
                #3;
                if (bus4.out_valid) lat = c;
            end
            chk($sformatf("tbl%0d_latency", t), lat, 4);
            chk($sformatf("tbl%0d_result", t), {bus4.Sum, bus4.Cout, bus4.Overflow}, tbl[t].exp);
            @(negedge clk);
            #3;
            chk($sformatf("tbl%0d_pulse", t), bus4.out_valid, 0);
        end

        // 20 back-to-back random beats with a 3-cycle consumer stall.
        for (int j = 0; j < 20; j++) begin
            ra[j] = 16'($urandom);
            rb[j] = 16'($urandom);
            rc[j] = 1'($urandom_range(0, 1));
            rs[j] = 1'($urandom_range(0, 1));
        end
        pops0 = pops;
        i = 0;
        cyc = 0;
        while (i < 20 && cyc < 100) begin
            @(negedge clk);
            bus4.out_ready = !(cyc >= 8 && cyc < 11);
            bus4.in_valid = 1; bus4.A = ra[i]; bus4.B = rb[i];
            bus4.Cin = rc[i]; bus4.Sub = rs[i];
            #1;
            if (bus4.in_ready) i++;
            cyc++;
        end
        chk("stream_sent", i, 20);
        @(negedge clk);
        bus4.in_valid = 0;
        bus4.out_ready = 1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(negedge clk);
        #3;
        chk("stream_drained", exp_q.size(), 0);
        chk("stream_count", pops - pops0, 20);

        // Reset with three beats in flight; accept attempted during reset.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            bus4.in_valid = 1; bus4.A = 16'h1111 * (j + 1); bus4.B = 16'h0101;
            bus4.Cin = 0; bus4.Sub = 0;
        end
        @(negedge clk);
        rst = 1'b1;
        bus4.A = 16'hABCD;
        #3;
        chk("rstmid_in_ready", bus4.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        bus4.in_valid = 0;
        #3;
        chk("rstmid_out_valid", bus4.out_valid, 0);
        chk("rstmid_result", {bus4.Sum, bus4.Cout, bus4.Overflow}, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            #3;
            if (bus4.out_valid) seen = 1;
        end
        chk("rstmid_no_ghost", seen, 0);
        @(negedge clk);
        bus4.in_valid = 1; bus4.A = 16'h0F0F; bus4.B = 16'h00F1; bus4.Cin = 1; bus4.Sub = 0;
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) bus4.in_valid = 0;
            #3;
            if (bus4.out_valid) lat = c;
        end
        chk("rstmid_new_latency", lat, 4);
        chk("rstmid_new_result", {bus4.Sum, bus4.Cout, bus4.Overflow}, {16'h1001, 1'b0, 1'b0});

        // Same carry-chain vectors through SEG = 1, 4, 16.
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            bus1.in_valid = 1;  bus1.A = sc2[v].a;  bus1.B = sc2[v].b;  bus1.Cin = 0;  bus1.Sub = 0;
            bus4.in_valid = 1;  bus4.A = sc2[v].a;  bus4.B = sc2[v].b;  bus4.Cin = 0;  bus4.Sub = 0;
            bus16.in_valid = 1; bus16.A = sc2[v].a; bus16.B = sc2[v].b; bus16.Cin = 0; bus16.Sub = 0;
            lat1 = 0; lat4 = 0; lat16 = 0;
            r1 = '0; r4 = '0; r16 = '0;
            for (int c = 1; c <= 24; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    bus1.in_valid = 0; bus4.in_valid = 0; bus16.in_valid = 0;
                end
                #3;
                if (bus1.out_valid && lat1 == 0) begin
                    lat1 = c; r1 = {bus1.Sum, bus1.Cout, bus1.Overflow};
                end
                if (bus4.out_valid && lat4 == 0) begin
                    lat4 = c; r4 = {bus4.Sum, bus4.Cout, bus4.Overflow};
                end
                if (bus16.out_valid && lat16 == 0) begin
                    lat16 = c; r16 = {bus16.Sum, bus16.Cout, bus16.Overflow};
                end
            end
            chk($sformatf("seg1_v%0d_latency", v), lat1, 16);
            chk($sformatf("seg4_v%0d_latency", v), lat4, 4);
            chk($sformatf("seg16_v%0d_latency", v), lat16, 1);
            chk($sformatf("seg1_v%0d_result", v), r1, sc2[v].exp);
            chk($sformatf("seg4_v%0d_result", v), r4, sc2[v].exp);
            chk($sformatf("seg16_v%0d_result", v), r16, sc2[v].exp);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
